// File: rtl/mem_miss_arbiter.sv
// Memory-port arbiter for I-cache and D-cache misses and D-cache write-through stores.
// Sequences eight word reads per block fill and steers the returned words back to the requesting cache.
module mem_miss_arbiter #(
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_D_WRITE,
        S_D_FILL,
        S_I_FILL,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:4] r_base;
    logic        r_is_d;
    logic        r_issuing;
    logic [2:0]  r_issue_cnt;
    logic [2:0]  r_ret_cnt;
    logic        r_mem_en;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_i_done;
    logic        r_d_done;

    logic        w_filling;
    logic        w_ret;

    assign w_filling = (r_state == S_D_FILL) || (r_state == S_I_FILL);
    // Returns are counted rather than timed, so the fill tolerates any fixed memory latency.
    assign w_ret     = w_filling & mem_data_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_is_d      <= 1'b0;
            r_issuing   <= 1'b0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            case (r_state)
                S_IDLE: begin
                    r_mem_en   <= 1'b0;
                    r_mem_addr <= '0;
                    if (d_req && d_wr) begin
                        r_state     <= S_D_WRITE;
                        r_is_d      <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end else if (d_req || i_req) begin
                        // Word 0 issues on entry; the counter then points at word 1.
                        r_state     <= d_req ? S_D_FILL : S_I_FILL;
                        r_is_d      <= d_req;
                        r_base      <= d_req ? d_addr[15:4] : i_addr[15:4];
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= {(d_req ? d_addr[15:4] : i_addr[15:4]), 4'h0};
                        r_issue_cnt <= 3'd1;
                        r_issuing   <= 1'b1;
                        r_ret_cnt   <= '0;
                    end
                end
                S_D_WRITE: begin
                    r_mem_en   <= 1'b0;
                    r_mem_addr <= '0;
                    r_d_done   <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_D_FILL, S_I_FILL: begin
                    if (r_issuing) begin
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= {r_base, r_issue_cnt, 1'b0};
                        r_issue_cnt <= r_issue_cnt + 3'd1;
                        if (r_issue_cnt == LAST_WORD) begin
                            r_issuing <= 1'b0;
                        end
                    end else begin
                        r_mem_en   <= 1'b0;
                        r_mem_addr <= '0;
                    end
                    if (mem_data_valid) begin
                        r_ret_cnt <= r_ret_cnt + 3'd1;
                        if (r_ret_cnt == LAST_WORD) begin
                            r_state  <= S_DONE;
                            r_d_done <= r_is_d;
                            r_i_done <= ~r_is_d;
                        end
                    end
                end
                S_DONE: begin
                    r_mem_en   <= 1'b0;
                    r_mem_addr <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en       = r_mem_en;
    assign mem_wr       = r_mem_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign fill_data    = mem_rdata;
    assign fill_word    = r_ret_cnt;
    assign i_fill_valid = w_ret & ~r_is_d;
    assign d_fill_valid = w_ret & r_is_d;
    assign i_done       = r_i_done;
    assign d_done       = r_d_done;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/mem_miss_arbiter.md
Name: mem_miss_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single multi-cycle main memory (4-cycle pipelined read latency).
- Arbitrates cache-miss block fills and data write-through stores onto one memory port.
- Sequences the 8 word reads of a 16-byte block fill.
- Steers returned words, with their word index, back to the requesting cache.

Parameters:
MEM_LATENCY, 4, cycles from a read issue (mem_en=1, mem_wr=0) to its mem_data_valid
WORDS_PER_BLOCK, 8, 16-bit words per cache block (block = 16 bytes)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
i_req  input  1  I-cache miss request; held high until i_done
i_addr  input  16  I-cache miss byte address
d_req  input  1  D-cache request (miss fill or store); held high until d_done
d_wr  input  1  1 = store write-through, 0 = miss fill; valid with d_req
d_addr  input  16  D-cache byte address
d_wdata  input  16  store data; valid with d_req & d_wr
mem_rdata  input  16  main-memory read data
mem_data_valid  input  1  mem_rdata valid this cycle
mem_en  output  1  memory access enable
mem_wr  output  1  memory write strobe
mem_addr  output  16  memory byte address
mem_wdata  output  16  memory write data
fill_data  output  16  returned word, combinationally equal to mem_rdata
fill_word  output  3  word index within block of fill_data
i_fill_valid  output  1  fill_data belongs to the I-cache fill
d_fill_valid  output  1  fill_data belongs to the D-cache fill
i_done  output  1  one-cycle pulse: I fill complete
d_done  output  1  one-cycle pulse: D fill or store complete
busy  output  1  state != IDLE

Behaviour:
- Reset: asynchronous on rst_n=0.
  - State → IDLE; issue and return counters → 0.
  - All outputs 0; mem_addr and mem_wdata are 0.
- States: IDLE, D_WRITE, D_FILL, I_FILL, DONE.
- Transitions from IDLE, evaluated each clock:
  - d_req & d_wr → D_WRITE.
  - else d_req → D_FILL.
  - else i_req → I_FILL.
  - Data side has priority over instruction side on simultaneous requests.
- The block base address (req_addr & 16'hFFF0) and the requester are latched on entry to D_FILL or I_FILL.
  - Requester inputs are ignored until the next IDLE.
- Issue phase (D_FILL / I_FILL):
  - Issue counter k = 0..7 advances one per cycle.
  - Each issue cycle drives mem_en=1, mem_wr=0, mem_addr = base + 2k.
  - After k=7, mem_en=0 for the rest of the fill.
- Return phase (overlaps issue):
  - Each mem_data_valid in D_FILL / I_FILL asserts d_fill_valid or i_fill_valid (the latched requester) for that cycle.
  - fill_word = return counter, then the return counter increments.
  - The 8th return (fill_word=7) moves the state to DONE.
  - Expected timing: first return MEM_LATENCY cycles after the first issue; last return 7 cycles later. Total fill = 12 cycles.
- D_WRITE (one cycle):
  - mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - Next state DONE.
- DONE (one cycle):
  - Pulse i_done or d_done for the completed requester.
  - Next state IDLE.
  - A request still high in that IDLE cycle is arbitrated normally, so a pending i_req behind a d_req starts one cycle after DONE.
- mem_data_valid while in IDLE, D_WRITE or DONE is ignored: no fill_valid, no counter change.
- A requester dropping its request mid-fill does not abort the fill; it completes and pulses done.
- Reset asserted mid-fill:
  - Immediate return to IDLE; in-flight memory responses arriving afterwards are ignored.
  - No done pulse is generated.
- busy = 1 in every state except IDLE.
- Word index and address arithmetic are 3-bit and 16-bit respectively.
  - Base alignment guarantees base + 14 never carries out of bit 3, so no wrap occurs.

Test Plan:
- Single I-fill:
  - Stimulus: i_req=1, i_addr=16'h0046.
  - mem_addr issued in order: 0040, 0042, …, 004E on consecutive cycles.
  - i_fill_valid with fill_word 0..7 on returns.
  - i_done pulses exactly once, 12 cycles after the first issue + 1.
  - d_fill_valid never asserts.
- Simultaneous requests:
  - Stimulus: i_req and d_req (d_wr=0, d_addr=16'h1234) rise together.
  - D fill of base 1230 completes with d_done first.
  - I fill issue starts on the cycle after DONE.
- Store write-through:
  - Stimulus: d_req=1, d_wr=1, d_addr=16'h2002, d_wdata=16'hBEEF.
  - One cycle with mem_en=1, mem_wr=1, mem_addr=2002, mem_wdata=BEEF.
  - d_done on the next cycle; busy=0 after.
- Stray valid:
  - Stimulus: mem_data_valid=1 while idle.
  - No fill_valid, counters unchanged.
  - A subsequent fill still returns fill_word starting at 0.
- Reset mid-fill:
  - Stimulus: assert rst_n=0 after 5 issues.
  - All outputs 0 asynchronously; no done pulse.
  - Late mem_data_valid pulses ignored.
  - A new i_req fill starts cleanly at word 0.
- Request dropped mid-fill:
  - Stimulus: deassert i_req at cycle 3.
  - All 8 words still issued and returned; i_done still pulses.
